// File: rtl/uart_byte_receiver.sv
// uart_byte_receiver: 8N1 UART receiver with 16x oversampling, 3-sample
// majority vote, a one-entry valid/ready holding register, and framing /
// overrun error pulses.
module uart_byte_receiver #(
  parameter int unsigned TICK_DIV = 651
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t      state, state_nxt;
  logic        rx_meta, rxs;
  logic [15:0] tick_cnt;
  logic        tick;
  logic [3:0]  sc;
  logic [2:0]  smp;
  logic        voted;
  logic        bit_end;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        hold_free;

  // FSM-driven controls
  logic sc_clear, bit_clr, shift_en, load_evt, ovr_evt, ferr_evt;

  // Two-flop synchronizer; idles high so reset does not look like a start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rxs     <= rx_meta;
    end
  end

  // Free-running oversample tick divider
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     tick_cnt <= '0;
    else if (tick)  tick_cnt <= '0;
    else            tick_cnt <= tick_cnt + 16'd1;
  end

  assign tick    = (tick_cnt == 16'(TICK_DIV - 1));
  assign bit_end = tick && (sc == 4'd15);
  assign voted   = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);

  // Hold register can accept a new byte if empty or being drained this cycle
  assign hold_free = ~rx_valid | rx_ready;

  // Per-bit sample counter; the detecting tick counts as sample 0 of start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         sc <= '0;
    else if (sc_clear)                  sc <= 4'd1;
    else if (tick && state != S_IDLE)   sc <= sc + 4'd1;
  end

  // Capture mid-bit samples for the majority vote
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp <= '0;
    end else if (tick && state != S_IDLE) begin
      case (sc)
        4'd7:    smp[0] <= rxs;
        4'd8:    smp[1] <= rxs;
        4'd9:    smp[2] <= rxs;
        default: ;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (tick && !rxs) state_nxt = S_START;
      S_START: if (bit_end) state_nxt = voted ? S_IDLE : S_DATA;
      S_DATA:  if (bit_end && bit_idx == 3'd7) state_nxt = S_STOP;
      S_STOP:  if (bit_end) state_nxt = voted ? S_IDLE : S_BREAK;
      S_BREAK: if (tick && rxs) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    sc_clear = 1'b0;
    bit_clr  = 1'b0;
    shift_en = 1'b0;
    load_evt = 1'b0;
    ovr_evt  = 1'b0;
    ferr_evt = 1'b0;
    case (state)
      S_IDLE:  sc_clear = tick && !rxs;
      S_START: bit_clr  = bit_end && !voted;
      S_DATA:  shift_en = bit_end;
      S_STOP: begin
        if (bit_end) begin
          if (!voted)         ferr_evt = 1'b1;
          else if (hold_free) load_evt = 1'b1;
          else                ovr_evt  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Bit index and LSB-first shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      if (bit_clr)       bit_idx <= '0;
      else if (shift_en) bit_idx <= bit_idx + 3'd1;
      if (shift_en)      shreg   <= {voted, shreg[7:1]};
    end
  end

  // Holding register; a load in the handshake cycle replaces the drained byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else if (load_evt) begin
      rx_data  <= shreg;
      rx_valid <= 1'b1;
    end else if (rx_valid && rx_ready) begin
      rx_valid <= 1'b0;
    end
  end

  // Registered one-cycle error pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr_evt;
      overrun   <= ovr_evt;
    end
  end

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Directed testbench for uart_byte_receiver at TICK_DIV = 4 (64 clk per bit).
module tb_uart_byte_receiver;

  localparam int unsigned BIT_CLK = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  // Event counters gathered by the monitor
  int       valid_rises = 0;
  int       valid_cycles = 0;
  int       ferr_cnt = 0;
  int       ovr_cnt = 0;
  logic [7:0] last_data = 8'h00;
  logic     prev_valid = 1'b0;

  int b_rises, b_cycles, b_ferr, b_ovr;

  uart_byte_receiver #(.TICK_DIV(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .uart_rx   (uart_rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid && !prev_valid) begin
      valid_rises <= valid_rises + 1;
      last_data   <= rx_data;
    end
    if (rx_valid)  valid_cycles <= valid_cycles + 1;
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (overrun)   ovr_cnt  <= ovr_cnt + 1;
    prev_valid <= rx_valid;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic mark();
    @(negedge clk);
    b_rises  = valid_rises;
    b_cycles = valid_cycles;
    b_ferr   = ferr_cnt;
    b_ovr    = ovr_cnt;
  endtask

  task automatic hold_line(input logic v, input int unsigned bits);
    uart_rx = v;
    repeat (bits * BIT_CLK) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    hold_line(1'b0, 1);
    for (int unsigned i = 0; i < 8; i++) hold_line(b[i], 1);
    hold_line(stop, 1);
  endtask

  initial begin
    rst_n    = 1'b0;
    uart_rx  = 1'b1;
    rx_ready = 1'b0;
    repeat (5) @(posedge clk);
    rst_n = 1'b1;

    // Idle line after reset
    mark();
    repeat (200) @(posedge clk);
    @(negedge clk);
    check("rst_data",   int'(rx_data),   8'h00);
    check("rst_valid",  int'(rx_valid),  0);
    check("rst_ferr",   int'(frame_err), 0);
    check("rst_ovr",    int'(overrun),   0);
    check("idle_rises", valid_rises - b_rises, 0);

    // Single byte with consumer ready: valid for one clock
    rx_ready = 1'b1;
    mark();
    send_frame(8'hA5, 1'b1);
    hold_line(1'b1, 2);
    @(negedge clk);
    check("a5_data",   int'(last_data), 8'hA5);
    check("a5_cycles", valid_cycles - b_cycles, 1);
    check("a5_rises",  valid_rises - b_rises, 1);
    check("a5_ferr",   ferr_cnt - b_ferr, 0);
    check("a5_ovr",    ovr_cnt - b_ovr, 0);

    // Back-to-back with consumer stalled: second byte overruns
    rx_ready = 1'b0;
    mark();
    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    hold_line(1'b1, 2);
    @(negedge clk);
    check("ovr_cnt",   ovr_cnt - b_ovr, 1);
    check("ovr_data",  int'(rx_data), 8'h3C);
    check("ovr_valid", int'(rx_valid), 1);
    check("ovr_rises", valid_rises - b_rises, 1);
    check("ovr_ferr",  ferr_cnt - b_ferr, 0);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    @(negedge clk);
    check("drain_valid", int'(rx_valid), 0);

    // Framing error, then line held low (break), then a good byte
    rx_ready = 1'b1;
    mark();
    send_frame(8'h55, 1'b0);
    hold_line(1'b0, 39);
    hold_line(1'b1, 2);
    @(negedge clk);
    check("brk_ferr",  ferr_cnt - b_ferr, 1);
    check("brk_rises", valid_rises - b_rises, 0);
    check("brk_ovr",   ovr_cnt - b_ovr, 0);
    mark();
    send_frame(8'h0F, 1'b1);
    hold_line(1'b1, 2);
    @(negedge clk);
    check("0f_data",  int'(last_data), 8'h0F);
    check("0f_rises", valid_rises - b_rises, 1);
    check("0f_ferr",  ferr_cnt - b_ferr, 0);

    // Short low glitch on idle line
    mark();
    uart_rx = 1'b0;
    repeat (20) @(posedge clk);
    hold_line(1'b1, 4);
    @(negedge clk);
    check("gl_rises", valid_rises - b_rises, 0);
    check("gl_ferr",  ferr_cnt - b_ferr, 0);
    check("gl_ovr",   ovr_cnt - b_ovr, 0);

    // Reset mid-frame, then a clean byte
    mark();
    hold_line(1'b0, 1);
    for (int unsigned i = 0; i < 3; i++) hold_line(1'b1, 1);
    hold_line(1'b1, 0);
    rst_n = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("mid_rst_valid", int'(rx_valid), 0);
    rst_n = 1'b1;
    hold_line(1'b1, 2);
    send_frame(8'h81, 1'b1);
    hold_line(1'b1, 2);
    @(negedge clk);
    check("81_data",  int'(last_data), 8'h81);
    check("81_rises", valid_rises - b_rises, 1);
    check("81_ferr",  ferr_cnt - b_ferr, 0);
    check("81_ovr",   ovr_cnt - b_ovr, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
